// File: rtl/mem_copy_master.sv
// Burst memory-to-memory copy engine: reads up to BURST words, buffers them, writes them back.
// Ports: clk/rst, start/src_addr/dst_addr/len command, busy/done/err status, mem_* request bus.
module mem_copy_master #(
  parameter int MEM_AW = 12,
  parameter int MEM_DW = 32,
  parameter int BURST  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MEM_AW-1:0] src_addr,
  input  logic [MEM_AW-1:0] dst_addr,
  input  logic [MEM_AW:0]   len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_write,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [MEM_DW-1:0] mem_wdata,
  input  logic [MEM_DW-1:0] mem_rdata,
  input  logic              mem_rdata_vld
);
  localparam int CW = $clog2(BURST) + 1;
  localparam int IW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0] BMAX = CW'(BURST);

  typedef enum logic [2:0] {IDLE, RD, DRAIN, WR, FIN} state_t;
  state_t state, state_nx;

  logic [MEM_AW-1:0] src, dst, src_nx, dst_nx;
  logic [MEM_AW:0]   rem, rem_nx;
  logic [CW-1:0]     n, k, c, n_nx, k_nx, c_nx;
  logic [MEM_DW-1:0] dbuf [BURST];
  logic [1:0]        quiet;

  logic              busy_nx, done_nx, err_nx;
  logic              req_nx, write_nx;
  logic [MEM_AW-1:0] addr_nx;
  logic [MEM_DW-1:0] wdata_nx;

  logic              last_k, vld, cap_ok, cap, stray, fill;
  logic [MEM_AW:0]   rem_after, rem_src;
  logic [CW-1:0]     n_next, kp1;

  // Reads issued before a reset may still return data; a short
  // post-reset window drops any such beats silently.
  assign vld       = mem_rdata_vld && (quiet == 2'd0);
  assign cap_ok    = (state == RD || state == DRAIN) && (c != n);
  assign cap       = vld && cap_ok;
  assign stray     = vld && !cap_ok;
  assign last_k    = (k == n - CW'(1));
  assign kp1       = k + CW'(1);
  // Buffer is full now, or becomes full with the beat arriving this cycle.
  assign fill      = (c == n) || (cap && (c == n - CW'(1)));
  assign rem_after = rem - (MEM_AW+1)'(n);
  assign rem_src   = (state == IDLE) ? len : rem_after;
  assign n_next    = (rem_src >= (MEM_AW+1)'(BURST)) ? BMAX
                                                     : rem_src[CW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = (len == '0) ? FIN : RD;
      RD:      if (last_k) state_nx = DRAIN;
      DRAIN:   if (fill) state_nx = WR;
      WR:      if (last_k) state_nx = (rem_after == '0) ? FIN : RD;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    src_nx   = src;
    dst_nx   = dst;
    rem_nx   = rem;
    n_nx     = n;
    k_nx     = k;
    c_nx     = cap ? c + CW'(1) : c;
    err_nx   = err | stray;
    req_nx   = 1'b0;
    write_nx = 1'b0;
    addr_nx  = mem_addr;
    wdata_nx = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          src_nx = src_addr;
          dst_nx = dst_addr;
          rem_nx = len;
          err_nx = stray;
          if (len != '0) begin
            n_nx    = n_next;
            k_nx    = '0;
            c_nx    = '0;
            req_nx  = 1'b1;
            addr_nx = src_addr;
          end
        end
      end
      RD: begin
        if (last_k) begin
          k_nx = '0;
        end else begin
          k_nx    = kp1;
          req_nx  = 1'b1;
          addr_nx = src + MEM_AW'(kp1);
        end
      end
      DRAIN: begin
        if (fill) begin
          k_nx     = '0;
          req_nx   = 1'b1;
          write_nx = 1'b1;
          addr_nx  = dst;
          // Single-word bursts complete on the same beat: bypass the buffer.
          wdata_nx = (cap && c == '0) ? mem_rdata : dbuf[0];
        end
      end
      WR: begin
        if (!last_k) begin
          k_nx     = kp1;
          req_nx   = 1'b1;
          write_nx = 1'b1;
          addr_nx  = dst + MEM_AW'(kp1);
          wdata_nx = dbuf[kp1[IW-1:0]];
        end else begin
          src_nx = src + MEM_AW'(n);
          dst_nx = dst + MEM_AW'(n);
          rem_nx = rem_after;
          if (rem_after != '0) begin
            n_nx    = n_next;
            k_nx    = '0;
            c_nx    = '0;
            req_nx  = 1'b1;
            addr_nx = src + MEM_AW'(n);
          end
        end
      end
      FIN: begin
      end
      default: begin
      end
    endcase
    busy_nx = state_nx inside {RD, DRAIN, WR};
    done_nx = (state_nx == FIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src       <= '0;
      dst       <= '0;
      rem       <= '0;
      n         <= '0;
      k         <= '0;
      c         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      quiet     <= 2'd3;
    end else begin
      src       <= src_nx;
      dst       <= dst_nx;
      rem       <= rem_nx;
      n         <= n_nx;
      k         <= k_nx;
      c         <= c_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      err       <= err_nx;
      mem_req   <= req_nx;
      mem_write <= write_nx;
      mem_addr  <= addr_nx;
      mem_wdata <= wdata_nx;
      quiet     <= (quiet == 2'd0) ? 2'd0 : quiet - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (cap) dbuf[c[IW-1:0]] <= mem_rdata;
  end

endmodule

// File: tb/tb_mem_copy_master.sv
// Self-checking bench for mem_copy_master: table of copy commands plus
// hand sequences (zero length, start while busy, spurious data, resets).
module tb_mem_copy_master;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int B  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [AW:0]   len = '0;
  logic          busy, done, err, mem_req, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_rdata_vld;

  always #5 clk = ~clk;

  mem_copy_master #(.MEM_AW(AW), .MEM_DW(DW), .BURST(B)) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .err(err),
    .mem_req(mem_req), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdata_vld(mem_rdata_vld)
  );

  // memory model: 2-cycle read latency, write committed at cycle end
  logic [DW-1:0] mem     [1<<AW];
  logic [DW-1:0] ref_mem [1<<AW];
  logic          p1_v = 1'b0, p2_v = 1'b0;
  logic [DW-1:0] p1_d = '0, p2_d = '0;
  logic          inject = 1'b0;

  always @(posedge clk) begin
    p1_v <= mem_req && !mem_write;
    p1_d <= mem[mem_addr];
    p2_v <= p1_v;
    p2_d <= p1_d;
    if (mem_req && mem_write) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata     = p2_d;
  assign mem_rdata_vld = p2_v | inject;

  int errors = 0;
  int checks = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;
  txn_t exp_q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit mon_on = 1'b0;
  int busy_cnt, done_cnt, done_cyc, first_req;

  always @(negedge clk) begin
    txn_t t;
    if (mon_on) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (mem_req) begin
        if (first_req < 0) first_req = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_req", {mem_write, mem_addr}, 0);
        end else begin
          t = exp_q.pop_front();
          chk("bus_txn", {mem_write, mem_addr, mem_write ? mem_wdata : 32'd0},
              {t.wr, t.addr, t.data});
        end
      end else begin
        chk("idle_bus", {mem_write, mem_wdata}, 0);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // reference forward copy: each burst read fully, then written
  task automatic plan(input logic [AW-1:0] s, input logic [AW-1:0] d, input int l);
    logic [DW-1:0] tmp [B];
    logic [AW-1:0] sa, da;
    int r, n;
    sa = s;
    da = d;
    r  = l;
    while (r > 0) begin
      n = (r > B) ? B : r;
      for (int i = 0; i < n; i++) begin
        exp_q.push_back('{1'b0, sa + AW'(i), '0});
        tmp[i] = ref_mem[sa + AW'(i)];
      end
      for (int i = 0; i < n; i++) begin
        exp_q.push_back('{1'b1, da + AW'(i), tmp[i]});
        ref_mem[da + AW'(i)] = tmp[i];
      end
      sa = sa + AW'(n);
      da = da + AW'(n);
      r  = r - n;
    end
  endtask

  task automatic check_mem(string nm);
    int bad = 0;
    for (int i = 0; i < (1 << AW); i++)
      if (mem[i] !== ref_mem[i]) begin
        bad = i;
        break;
      end
    chk(nm, {20'(bad), mem[bad]}, {20'(bad), ref_mem[bad]});
  endtask

  task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input int l, input int eb, input bit intrude);
    int s0;
    plan(s, d, l);
    busy_cnt  = 0;
    done_cnt  = 0;
    done_cyc  = -1;
    first_req = -1;
    step();
    src_addr = s;
    dst_addr = d;
    len      = (AW+1)'(l);
    start    = 1'b1;
    s0       = cyc;
    step();
    start = 1'b0;
    chk("err_clear", {31'd0, err}, 0);
    if (intrude) begin
      step();
      src_addr = 12'h050;
      dst_addr = 12'h950;
      len      = 13'd7;
      start    = 1'b1;
      step();
      start = 1'b0;
    end
    for (int i = 0; i < 500 && done_cnt == 0; i++) step();
    if (done_cnt == 0) chk("done_timeout", 0, 1);
    repeat (4) step();
    chk("busy_cycles", busy_cnt, eb);
    chk("done_count", done_cnt, 1);
    chk("done_cycle", done_cyc, s0 + 1 + eb);
    chk("first_req_cycle", first_req, (l > 0) ? s0 + 1 : -1);
    chk("queue_left", exp_q.size(), 0);
    chk("err_after", {31'd0, err}, 0);
    check_mem("mem_image");
  endtask

  typedef struct {
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    int            len;
    int            busy_cyc;
  } vec_t;
  vec_t vecs [7];

  initial begin
    vecs[0] = '{12'h010, 12'h800, 5, 14};
    vecs[1] = '{12'hFFE, 12'h100, 3, 8};
    vecs[2] = '{12'h020, 12'h024, 8, 20};
    vecs[3] = '{12'h030, 12'h032, 4, 10};
    vecs[4] = '{12'h0A0, 12'hA00, 1, 4};
    vecs[5] = '{12'h0B0, 12'hB00, 16, 40};
    vecs[6] = '{12'h0C0, 12'hC00, 6, 16};

    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = DW'(i);
      ref_mem[i] = DW'(i);
    end

    #1 rst = 1'b1;
    step();
    step();
    chk("reset_flags", {busy, done, err, mem_req, mem_write}, 0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_wdata", mem_wdata, 0);
    rst = 1'b0;
    repeat (4) step();
    mon_on = 1'b1;

    foreach (vecs[i])
      run_copy(vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].busy_cyc, 1'b0);

    // zero length
    busy_cnt  = 0;
    done_cnt  = 0;
    first_req = -1;
    step();
    src_addr = 12'h111;
    dst_addr = 12'h222;
    len      = '0;
    start    = 1'b1;
    step();
    start = 1'b0;
    chk("zero_done", {busy, done}, 2'b01);
    step();
    chk("zero_done_drop", {31'd0, done}, 0);
    repeat (3) step();
    chk("zero_busy", busy_cnt, 0);
    chk("zero_no_req", first_req, -1);
    chk("zero_done_count", done_cnt, 1);

    // start while busy is ignored
    run_copy(12'h040, 12'h900, 3, 8, 1'b1);

    // spurious read data while idle
    step();
    inject = 1'b1;
    step();
    inject = 1'b0;
    chk("spurious_err", {31'd0, err}, 1);
    repeat (3) step();
    chk("spurious_sticky", {31'd0, err}, 1);
    run_copy(12'h060, 12'hA40, 2, 6, 1'b0);

    // reset during the second write cycle
    mon_on = 1'b0;
    step();
    src_addr = 12'h200;
    dst_addr = 12'h300;
    len      = 13'd4;
    start    = 1'b1;
    step();
    start = 1'b0;
    begin
      int i;
      for (i = 0; i < 50 && !(mem_req && mem_write); i++) step();
      if (i == 50) chk("wr_timeout", 0, 1);
    end
    @(posedge clk);
    #1;
    chk("in_second_wr", {mem_req, mem_write}, 2'b11);
    rst = 1'b1;
    #1;
    chk("rst_now", {mem_req, busy, done, err}, 0);
    step();
    step();
    rst = 1'b0;
    chk("rst_one_word", mem[12'h300], ref_mem[12'h200]);
    chk("rst_no_second", mem[12'h301], ref_mem[12'h301]);
    ref_mem[12'h300] = ref_mem[12'h200];
    exp_q.delete();

    // reset while reads are in flight
    step();
    src_addr = 12'h210;
    dst_addr = 12'h310;
    len      = 13'd4;
    start    = 1'b1;
    step();
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (5) step();
    chk("inflight_no_err", {31'd0, err}, 0);
    chk("inflight_idle", {mem_req, busy}, 0);
    exp_q.delete();
    mon_on = 1'b1;

    run_copy(12'h200, 12'h300, 4, 10, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_copy_master.md
# mem_copy_master

Requester-side engine for the single-port memory request interface (`mem_req`/`mem_write`/`mem_addr`/`mem_wdata` out, `mem_rdata`/`mem_rdata_vld` in). On a `start` pulse it copies `len` words from `src_addr` to `dst_addr` in bursts. Each burst issues up to `BURST` back-to-back reads, buffers the returned data, then writes it out back-to-back. It sits in the testbench and datapath wherever a block must move data between regions of a `mem` instance.

## Interface
- `MEM_AW`, 12: memory address width in words.
- `MEM_DW`, 32: data width.
- `BURST`, 4: maximum words per read/write burst and buffer depth. Must be a power of two, ≥1.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  one-cycle command strobe. Sampled only while idle.
- `src_addr`  in  MEM_AW  first source word address, captured on `start`.
- `dst_addr`  in  MEM_AW  first destination word address, captured on `start`.
- `len`  in  MEM_AW+1  word count, 0 to 2^MEM_AW, captured on `start`.
- `busy`  out  1  high while a copy is in progress.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  sticky protocol error flag; cleared by an accepted `start`.
- `mem_req`  out  1  memory request valid.
- `mem_write`  out  1  1 = write, 0 = read; qualified by `mem_req`.
- `mem_addr`  out  MEM_AW  request address.
- `mem_wdata`  out  MEM_DW  write data.
- `mem_rdata`  in  MEM_DW  read data.
- `mem_rdata_vld`  in  1  read data valid.

## Operation
- All outputs are registered. Reset forces `busy`, `done`, `err`, `mem_req` and `mem_write` to 0, `mem_addr` to 0 and `mem_wdata` to 0, and the state to IDLE. Reset takes effect immediately, including mid-copy. No further requests are issued after reset, and read data still in flight afterwards is ignored without setting `err`.
- **IDLE:** `start`=1 captures `src`, `dst` and `len`, and clears `err`.
  - If `len`=0, go to DONE.
  - Otherwise go to RD with `n` = min(BURST, remaining).
  - `start` while not IDLE is ignored.
- **RD:** for `n` consecutive cycles drive `mem_req`=1, `mem_write`=0, `mem_addr`=`src`+k (k=0..n-1, modulo 2^MEM_AW). After the last read, go to DRAIN.
- **DRAIN:** `mem_req`=0. Each `mem_rdata_vld`=1 writes `mem_rdata` into `buf[c]` and increments `c`. When `c` reaches `n`, go to WR.
- **WR:** for `n` consecutive cycles drive `mem_req`=1, `mem_write`=1, `mem_addr`=`dst`+k, `mem_wdata`=`buf[k]`. Afterwards `src`+=n, `dst`+=n, remaining−=n (all address arithmetic modulo 2^MEM_AW).
  - If remaining>0, go to RD.
  - Otherwise go to DONE.
- **DONE:** `done`=1 for exactly one cycle, `busy`=0, then go to IDLE.
- Read data is also accepted during RD; capture runs in parallel with issuing.
- **Unexpected data:** `mem_rdata_vld`=1 while IDLE, DONE or WR, or when `c`=`n`, sets `err`. The data is discarded.
- When `mem_req`=0, `mem_write`=0 and `mem_wdata`=0. `mem_addr` holds its last value.
- Source and destination regions may overlap. Each burst is read completely before it is written, so overlap within one burst is safe. Overlap across bursts follows plain forward-copy semantics.

## Timing
- **Memory latency:** a read presented in cycle t has its data and `vld` visible in cycle t+2. A write presented in cycle t is committed at the end of cycle t.
- **Start:** `start` in cycle s puts the first read on the bus in cycle s+1. `busy`=1 from cycle s+1 through the last WR cycle.
- **Burst sequence:** last read in cycle t, DRAIN in t+1 and t+2, first write in t+3.
- **Burst cost:** 2n+2 cycles.
- **Copy cost:** sum over bursts, plus 1 cycle for DONE.
- **`len`=0:** `start` in cycle s gives `done`=1 in s+1, `busy` never rises, and no memory access occurs.
- **Back-to-back copies:** the earliest next `start` is accepted in the DONE cycle's successor (IDLE).

## Test plan
- **Multi-burst copy:** memory init_incr, `src`=0x010, `dst`=0x800, `len`=5, BURST=4.
  - Reads 0x010–0x013, then writes 0x800–0x803 with 0x10–0x13.
  - Then reads 0x014 and writes 0x804=0x14.
  - `busy` high 14 cycles, then a single `done` pulse, `err`=0.
- **Address wrap:** `src`=0xFFE, `dst`=0x100, `len`=3.
  - Read addresses 0xFFE, 0xFFF, 0x000.
  - Memory 0x100–0x102 equals the old 0xFFE, 0xFFF, 0x000.
- **Zero length:** `len`=0, so `done` the cycle after `start`, `mem_req` never 1, `busy` never 1.
- **Start while busy:** a second `start` with `len`=7 mid-copy is ignored. Exactly the first command's words are written and one `done` is seen.
- **Reset mid-copy:** assert `rst` during the second WR cycle.
  - `mem_req`, `busy`, `done` and `err` go to 0 immediately.
  - Only one destination word is written.
  - A new copy started after reset completes correctly.
- **Spurious data:** inject `mem_rdata_vld`=1 while IDLE, so `err`=1 and stays 1. The next accepted `start` clears it, and the copy data is unaffected.
